clock_stepper: RTL

Parametrised debug clock source for the RISC-V lab core, replacing the fixed four-tap divider. Produces a registered, glitch-free divided clock `outclk` plus a one-cycle `tick` enable. Supports free-run, halt and single-step modes. The selected division is applied only at period boundaries, so switches never produce runt pulses. Sits between the board oscillator/button inputs and the core clock or clock-enable.

---
 rtl/clock_stepper.sv | 136 +++++++++++++
 1 files changed

// File: rtl/clock_stepper.sv
// clock_stepper: debug clock source for the RISC-V lab core.
// Produces a flop-driven divided clock plus a one-cycle tick enable.
// It supports free-run, halt and single-step modes. The division tap
// is latched at every period start, so a switch never truncates a
// phase or produces a runt pulse.
//
// Ports:
//   clk    - system clock
//   rst    - asynchronous active-high reset
//   SW     - tap selector; entry SW of TAPS gives exponent k, half-period 2**k
//   mode   - 00 run, 01 halt, 10 single-step, 11 run
//   step   - asynchronous (debounced) step button
//   outclk - divided clock, driven directly from a flop
//   tick   - high during the first high cycle of every outclk period
//   busy   - high while a period is in progress (HIGH or LOW)
//   pcount - number of outclk periods started, wrapping
module clock_stepper #(
  parameter int                       CNT_W  = 32,
  parameter int                       SEL_W  = 2,
  parameter logic [8*(2**SEL_W)-1:0]  TAPS   = 32'h18_0F_07_00,
  parameter int                       PCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEL_W-1:0]  SW,
  input  logic [1:0]        mode,
  input  logic              step,
  output logic              outclk,
  output logic              tick,
  output logic              busy,
  output logic [PCNT_W-1:0] pcount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [SEL_W-1:0]  sel_q;
  logic              step_sync_p0;
  logic              step_sync_p1;
  logic              step_hist_p2;

  logic [7:0]        tap_k;
  logic [CNT_W-1:0]  last_cnt;
  logic              phase_end;
  logic              run_mode;
  logic              step_edge;

  // The tap in use belongs to the period, not to the live switch value.
  assign tap_k     = TAPS[{sel_q, 3'b000} +: 8];
  assign last_cnt  = (CNT_W'(1) << tap_k) - CNT_W'(1);
  assign phase_end = (cnt == last_cnt);
  // Mode 11 is not a separate mode; it behaves exactly like run.
  assign run_mode  = (mode == 2'b00) || (mode == 2'b11);
  // One-cycle pulse on a synchronised rising edge of the button. It is
  // only consumed in IDLE with step mode selected; otherwise it is lost.
  assign step_edge = step_sync_p1 & ~step_hist_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      sel_q        <= '0;
      outclk       <= 1'b0;
      tick         <= 1'b0;
      busy         <= 1'b0;
      pcount       <= '0;
      step_sync_p0 <= 1'b0;
      step_sync_p1 <= 1'b0;
      step_hist_p2 <= 1'b0;
    end else begin
      // step synchroniser -> history stage
      step_sync_p0 <= step;
      step_sync_p1 <= step_sync_p0;
      step_hist_p2 <= step_sync_p1;

      tick <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (run_mode || ((mode == 2'b10) && step_edge)) begin
            state  <= HIGH;
            sel_q  <= SW;
            outclk <= 1'b1;
            tick   <= 1'b1;
            busy   <= 1'b1;
            pcount <= pcount + PCNT_W'(1);
          end
        end

        HIGH: begin
          // The high phase always completes into LOW, whatever the mode.
          if (phase_end) begin
            state  <= LOW;
            cnt    <= '0;
            outclk <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        LOW: begin
          if (phase_end) begin
            cnt <= '0;
            if (run_mode) begin
              // Back-to-back period: no idle gap cycle.
              state  <= HIGH;
              sel_q  <= SW;
              outclk <= 1'b1;
              tick   <= 1'b1;
              pcount <= pcount + PCNT_W'(1);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state  <= IDLE;
          cnt    <= '0;
          outclk <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
